stw_test_sequencer: RTL and testbench

Upstream controller for the self-test-while-running (STW) interface of a row/column of systolic MAC PEs. On request it broadcasts a fixed set of four test vectors to all attached PEs: loads operands and expected value, pulses start, then collects each PE's completion and pass/fail. It accumulates a sticky per-PE fault map, which array control uses for bypass/proxy decisions.

---
 rtl/stw_test_sequencer_if.sv | 22 ++
 rtl/stw_test_sequencer.sv | 100 ++++++++++
 tb/tb_stw_test_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/stw_test_sequencer_if.sv
// stw_test_sequencer_if: broadcast test bus between the STW sequencer and its PEs
interface stw_test_sequencer_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_PE = 4
);
  logic stw_test_load_en;
  logic stw_start;
  logic [WORD_SIZE-1:0] stw_mult_op1;
  logic [WORD_SIZE-1:0] stw_mult_op2;
  logic [WORD_SIZE-1:0] stw_add_op;
  logic [WORD_SIZE-1:0] stw_expected;
  logic [NUM_PE-1:0] stw_complete;
  logic [NUM_PE-1:0] stw_result;
  modport master (
    output stw_test_load_en, stw_start, stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected,
    input  stw_complete, stw_result
  );
  modport slave (
    input  stw_test_load_en, stw_start, stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected,
    output stw_complete, stw_result
  );
endinterface

// File: rtl/stw_test_sequencer.sv
// stw_test_sequencer: broadcasts four self-test vectors to the PEs and keeps a sticky fault map
module stw_test_sequencer #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_PE = 4,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic test_req,
  output logic test_busy,
  output logic test_done,
  output logic [NUM_PE-1:0] fault_map,
  output logic any_fault,
  stw_test_sequencer_if.master stw
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [2*WORD_SIZE-1:0] ALT = {WORD_SIZE{2'b01}};
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_PE-1:0] seen_q, seen_d, fault_q, fault_d;
  logic [WORD_SIZE-1:0] op1_q, op1_d, op2_q, op2_d, add_q, add_d, exp_q, exp_d;
  logic [WORD_SIZE-1:0] v_op1, v_op2, v_add;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    seen_d = seen_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: if (test_req) begin
        state_d = LOAD;
        fault_d = '0;
        idx_d = '0;
      end
      LOAD: state_d = START;
      START: begin
        state_d = WAIT;
        seen_d = '0;
        cnt_d = '0;
      end
      WAIT: begin
        seen_d = seen_q | ~stw.stw_complete;
        cnt_d = cnt_q + CW'(1);
        // seen_q guards against the stale complete=1 left over from the previous vector
        if (&(seen_q & stw.stw_complete) || cnt_q == CW'(TIMEOUT - 1)) state_d = CHECK;
      end
      CHECK: begin
        fault_d = fault_q | ~(seen_q & stw.stw_complete) | ~stw.stw_result;
        state_d = idx_q == 2'd3 ? DONE : LOAD;
        idx_d = idx_q == 2'd3 ? idx_q : idx_q + 2'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    v_op1 = idx_d == 2'd0 ? '0 : idx_d == 2'd1 ? '1 : idx_d == 2'd2 ? ALT[WORD_SIZE-1:0] : WORD_SIZE'(1);
    v_op2 = idx_d == 2'd0 ? '0 : WORD_SIZE'(1);
    v_add = idx_d == 2'd2 ? ~ALT[WORD_SIZE-1:0] : idx_d == 2'd3 ? '1 : '0;
    op1_d = state_d == LOAD ? v_op1 : op1_q;
    op2_d = state_d == LOAD ? v_op2 : op2_q;
    add_d = state_d == LOAD ? v_add : add_q;
    exp_d = state_d == LOAD ? v_op1 * v_op2 + v_add : exp_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      seen_q <= '0;
      fault_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      add_q <= '0;
      exp_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      seen_q <= seen_d;
      fault_q <= fault_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      add_q <= add_d;
      exp_q <= exp_d;
    end
  end
  assign test_busy = state_q != IDLE;
  assign test_done = state_q == DONE;
  assign fault_map = fault_q;
  assign any_fault = |fault_q;
  assign stw.stw_test_load_en = state_q == LOAD;
  assign stw.stw_start = state_q == START;
  assign stw.stw_mult_op1 = op1_q;
  assign stw.stw_mult_op2 = op2_q;
  assign stw.stw_add_op = add_q;
  assign stw.stw_expected = exp_q;
endmodule

// File: tb/tb_stw_test_sequencer.sv
// tb_stw_test_sequencer: PE models plus a run-schedule model checked every cycle, and directed scenarios
module tb_stw_test_sequencer;
  localparam int W = 16, N = 4, TO = 16;
  logic clk = 0, rst = 0, test_req = 0;
  logic test_busy, test_done, any_fault;
  logic [N-1:0] fault_map;
  logic [N-1:0] stuck = '0, fail_ones = '0, pe_cpl, pe_res;
  logic [W-1:0] pe_calc;
  int pe_t[N];
  int total = 0, bad = 0, ld_cnt = 0, st_cnt = 0, cyc, guard;
  logic [W-1:0] cap[16];
  logic m_busy = 0;
  int m_rc = 0, m_L = 6, m_ivi = 0;
  logic [N-1:0] m_fault = '0;
  logic [W-1:0] want[16] = '{16'h0, 16'h0, 16'h0, 16'h0,
                             16'hFFFF, 16'h1, 16'h0, 16'hFFFF,
                             16'h5555, 16'h1, 16'hAAAA, 16'hFFFF,
                             16'h1, 16'h1, 16'hFFFF, 16'h0};
  stw_test_sequencer_if #(.WORD_SIZE(W), .NUM_PE(N)) bus ();
  stw_test_sequencer #(.WORD_SIZE(W), .NUM_PE(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .test_req(test_req), .test_busy(test_busy), .test_done(test_done),
    .fault_map(fault_map), .any_fault(any_fault), .stw(bus)
  );
  assign bus.stw_complete = pe_cpl;
  assign bus.stw_result = pe_res;
  assign pe_calc = bus.stw_mult_op1 * bus.stw_mult_op2 + bus.stw_add_op;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] vop1(input int k);
    logic [2*W-1:0] alt;
    alt = {W{2'b01}};
    return k == 0 ? '0 : k == 1 ? '1 : k == 2 ? alt[W-1:0] : W'(1);
  endfunction
  function automatic logic [W-1:0] vop2(input int k);
    return k == 0 ? '0 : W'(1);
  endfunction
  function automatic logic [W-1:0] vadd(input int k);
    logic [2*W-1:0] alt;
    alt = {W{2'b10}};
    return k == 2 ? alt[W-1:0] : k == 3 ? '1 : '0;
  endfunction
  function automatic logic [W-1:0] vexp(input int k);
    logic [W-1:0] r;
    r = vop1(k) * vop2(k) + vadd(k);
    return r;
  endfunction
  function automatic logic [N-1:0] vec_fault(input int k);
    return stuck | (k == 1 ? fail_ones : '0);
  endfunction
  // Compliant PE: complete drops one edge after start and rises two edges later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_cpl <= '1;
      pe_res <= '1;
      for (int i = 0; i < N; i++) pe_t[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.stw_start && !stuck[i]) begin
          pe_cpl[i] <= 1'b0;
          pe_t[i] <= 1;
          pe_res[i] <= pe_calc == bus.stw_expected && !(fail_ones[i] && bus.stw_mult_op1 == '1);
        end else if (!pe_cpl[i]) begin
          if (pe_t[i] == 0) pe_cpl[i] <= 1'b1;
          else pe_t[i] <= pe_t[i] - 1;
        end
      end
    end
  end
  // Run model: each vector spans L = load + start + wait + check cycles, done lands at 1+4L
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0;
      m_rc <= 0;
      m_fault <= '0;
      m_ivi <= 0;
      m_L <= 6;
    end else if (!m_busy) begin
      if (test_req) begin
        m_busy <= 1;
        m_rc <= 1;
        m_fault <= '0;
        m_L <= 3 + (|stuck ? TO : 3);
      end
    end else begin
      if (m_rc == 1 + 4 * m_L) begin
        m_busy <= 0;
        m_ivi <= 3;
      end else m_rc <= m_rc + 1;
      if (m_rc % m_L == 0 && m_rc <= 4 * m_L) m_fault <= m_fault | vec_fault(m_rc / m_L - 1);
    end
  end
  always @(negedge clk) begin
    int k, ph;
    logic de, le, se;
    k = m_busy ? ((m_rc - 1) / m_L > 3 ? 3 : (m_rc - 1) / m_L) : m_ivi;
    ph = m_busy ? (m_rc - 1) % m_L : -1;
    de = m_busy && m_rc == 1 + 4 * m_L;
    le = m_busy && !de && ph == 0;
    se = m_busy && !de && ph == 1;
    chk("busy", 32'(test_busy), 32'(m_busy));
    chk("done", 32'(test_done), 32'(de));
    chk("load_en", 32'(bus.stw_test_load_en), 32'(le));
    chk("start", 32'(bus.stw_start), 32'(se));
    chk("fault_map", 32'(fault_map), 32'(m_fault));
    chk("any_fault", 32'(any_fault), 32'(|m_fault));
    chk("op1", 32'(bus.stw_mult_op1), 32'(vop1(k)));
    chk("op2", 32'(bus.stw_mult_op2), 32'(vop2(k)));
    chk("add", 32'(bus.stw_add_op), 32'(vadd(k)));
    chk("expected", 32'(bus.stw_expected), 32'(vexp(k)));
    if (bus.stw_test_load_en) begin
      if (ld_cnt < 4) begin
        cap[ld_cnt*4] = bus.stw_mult_op1;
        cap[ld_cnt*4+1] = bus.stw_mult_op2;
        cap[ld_cnt*4+2] = bus.stw_add_op;
        cap[ld_cnt*4+3] = bus.stw_expected;
      end
      ld_cnt++;
    end
    if (bus.stw_start) st_cnt++;
  end
  task automatic start_run;
    @(negedge clk);
    test_req = 1;
    @(negedge clk);
    test_req = 0;
  endtask
  task automatic wait_done(input int from, output int c);
    c = from;
    while (!test_done && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", 32'(test_done), 32'd1);
  endtask
  initial begin
    #1 rst = 1;
    #1;
    chk("rst_busy", 32'(test_busy), 32'd0);
    chk("rst_fault", 32'(fault_map), 32'd0);
    chk("rst_load", 32'(bus.stw_test_load_en), 32'd0);
    chk("rst_op1", 32'(bus.stw_mult_op1), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 0;
    start_run();
    wait_done(1, cyc);
    chk("s1_cycles", 32'(cyc), 32'd25);
    chk("s1_fault", 32'(fault_map), 32'd0);
    chk("s1_loads", 32'(ld_cnt), 32'd4);
    chk("s1_starts", 32'(st_cnt), 32'd4);
    for (int i = 0; i < 16; i++) chk($sformatf("bus_v%0d_%0d", i / 4, i % 4), 32'(cap[i]), 32'(want[i]));
    fail_ones = 4'b0100;
    start_run();
    wait_done(1, cyc);
    chk("s2_fault", 32'(fault_map), 32'h4);
    chk("s2_any", 32'(any_fault), 32'd1);
    fail_ones = '0;
    stuck = 4'b1000;
    start_run();
    wait_done(1, cyc);
    chk("s3_cycles", 32'(cyc), 32'd77);
    chk("s3_fault", 32'(fault_map), 32'h8);
    stuck = '0;
    fail_ones = 4'b0100;
    start_run();
    guard = 0;
    while (m_rc != 16 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("s4_pre_fault", 32'(fault_map), 32'h4);
    #2 rst = 1;
    #1;
    chk("s4_busy", 32'(test_busy), 32'd0);
    chk("s4_start", 32'(bus.stw_start), 32'd0);
    chk("s4_fault", 32'(fault_map), 32'd0);
    chk("s4_any", 32'(any_fault), 32'd0);
    chk("s4_add", 32'(bus.stw_add_op), 32'd0);
    chk("s4_exp", 32'(bus.stw_expected), 32'd0);
    @(negedge clk);
    #2 rst = 0;
    fail_ones = '0;
    start_run();
    wait_done(1, cyc);
    chk("s4_cycles", 32'(cyc), 32'd25);
    chk("s4_fault_after", 32'(fault_map), 32'd0);
    fail_ones = 4'b0100;
    start_run();
    repeat (9) @(negedge clk);
    test_req = 1;
    @(negedge clk);
    test_req = 0;
    wait_done(11, cyc);
    chk("s5_cycles", 32'(cyc), 32'd25);
    repeat (30) @(negedge clk);
    chk("s5_idle", 32'(test_busy), 32'd0);
    chk("s5_kept", 32'(fault_map), 32'h4);
    fail_ones = '0;
    start_run();
    chk("s5_cleared", 32'(fault_map), 32'd0);
    wait_done(1, cyc);
    chk("s5_cycles2", 32'(cyc), 32'd25);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
